// File: rtl/encoder_seq.sv
// encoder_seq: accepts an 8-bit request vector and emits the index of every set
// bit, one per transfer, lowest-first or highest-first, over a valid/ready pair.
module encoder_seq #(
    parameter int LOW_FIRST = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       In_Valid,
    output logic       In_Ready,
    input  logic [7:0] D,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic [2:0] Y,
    output logic       Last,
    output logic [3:0] Remaining,
    output logic       Empty
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pending_q, pending_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [2:0]  y_q, y_d;
    logic        last_q, last_d;
    logic [3:0]  remaining_q, remaining_d;
    logic        empty_q, empty_d;

    // Index of the next bit to emit: lowest set bit or highest set bit.
    function automatic logic [2:0] select_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        if (LOW_FIRST != 0) begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Number of set bits, 0..8.
    function automatic logic [3:0] popcount8(input logic [7:0] vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, vec[i]};
        end
        return cnt;
    endfunction

    // Next-state logic; all outputs are precomputed from the next pending
    // vector so that they come straight out of flops.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        empty_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (In_Valid && in_ready_q) begin
                    pending_d = D;
                    if (D != 8'd0) begin
                        state_d = EMIT;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (Out_Ready) begin
                    pending_d = pending_q & ~(8'b0000_0001 << y_q);
                    if (last_q) begin
                        pending_d = 8'd0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 8'd0;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == EMIT);
        y_d         = select_index(pending_d);
        remaining_d = popcount8(pending_d);
        last_d      = (state_d == EMIT) && (remaining_d == 4'd1);
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            pending_q   <= 8'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= 3'd0;
            last_q      <= 1'b0;
            remaining_q <= 4'd0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
            empty_q     <= empty_d;
        end
    end

    assign In_Ready  = in_ready_q;
    assign Out_Valid = out_valid_q;
    assign Y         = y_q;
    assign Last      = last_q;
    assign Remaining = remaining_q;
    assign Empty     = empty_q;

endmodule

// File: tb/tb_encoder_seq.sv
// Directed bench for encoder_seq: two instances (lowest-first and
// highest-first) share one stimulus stream and are checked against
// hand-computed index sequences.
module tb_encoder_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       In_Valid;
    logic [7:0] D;
    logic       Out_Ready;

    logic       in_ready_lo, out_valid_lo, last_lo, empty_lo;
    logic [2:0] y_lo;
    logic [3:0] rem_lo;
    logic       in_ready_hi, out_valid_hi, last_hi, empty_hi;
    logic [2:0] y_hi;
    logic [3:0] rem_hi;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    encoder_seq #(.LOW_FIRST(1)) dut_lo (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(in_ready_lo),
        .D(D), .Out_Valid(out_valid_lo), .Out_Ready(Out_Ready), .Y(y_lo),
        .Last(last_lo), .Remaining(rem_lo), .Empty(empty_lo)
    );

    encoder_seq #(.LOW_FIRST(0)) dut_hi (
        .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Ready(in_ready_hi),
        .D(D), .Out_Valid(out_valid_hi), .Out_Ready(Out_Ready), .Y(y_hi),
        .Last(last_hi), .Remaining(rem_hi), .Empty(empty_hi)
    );

    typedef struct {
        logic [7:0]  d;
        int          n;
        logic [23:0] lo;   // element k at [3k+:3]
        logic [23:0] hi;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Both instances idle with nothing pending.
    task automatic chk_idle(input string tag);
        chk({tag, " in_ready_lo"}, in_ready_lo, 1);
        chk({tag, " in_ready_hi"}, in_ready_hi, 1);
        chk({tag, " out_valid_lo"}, out_valid_lo, 0);
        chk({tag, " out_valid_hi"}, out_valid_hi, 0);
        chk({tag, " rem_lo"}, rem_lo, 0);
        chk({tag, " last_lo"}, last_lo, 0);
        chk({tag, " empty_lo"}, empty_lo, 0);
    endtask

    // Present D for one cycle starting at a negedge; returns at the negedge after acceptance.
    task automatic offer(input logic [7:0] v);
        In_Valid = 1'b1;
        D        = v;
        @(negedge Clk);
        In_Valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{8'hA6, 4, {3'd0,3'd0,3'd0,3'd0,3'd7,3'd5,3'd2,3'd1},
                             {3'd0,3'd0,3'd0,3'd0,3'd1,3'd2,3'd5,3'd7}};
        tbl[1] = '{8'h00, 0, 24'd0, 24'd0};
        tbl[2] = '{8'h81, 2, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd7,3'd0},
                             {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd7}};
        tbl[3] = '{8'h3C, 4, {3'd0,3'd0,3'd0,3'd0,3'd5,3'd4,3'd3,3'd2},
                             {3'd0,3'd0,3'd0,3'd0,3'd2,3'd3,3'd4,3'd5}};
        tbl[4] = '{8'hFF, 8, {3'd7,3'd6,3'd5,3'd4,3'd3,3'd2,3'd1,3'd0},
                             {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7}};
        tbl[5] = '{8'h10, 1, {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4},
                             {3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd4}};

        Reset     = 1'b1;
        In_Valid  = 1'b0;
        D         = 8'd0;
        Out_Ready = 1'b1;

        // Reset state, including In_Ready held low during reset.
        @(negedge Clk);
        chk("rst in_ready_lo", in_ready_lo, 0);
        chk("rst in_ready_hi", in_ready_hi, 0);
        chk("rst out_valid", out_valid_lo, 0);
        chk("rst y", y_lo, 0);
        chk("rst rem", rem_lo, 0);
        chk("rst empty", empty_lo, 0);
        Reset = 1'b0;
        @(negedge Clk);
        chk_idle("post-rst");

        // Table-driven vectors with Out_Ready held high.
        for (int v = 0; v < 6; v++) begin
            offer(tbl[v].d);
            if (tbl[v].n == 0) begin
                chk("zero empty_lo", empty_lo, 1);
                chk("zero empty_hi", empty_hi, 1);
                chk("zero out_valid", out_valid_lo, 0);
                chk("zero in_ready", in_ready_lo, 1);
                @(negedge Clk);
                chk("zero empty pulse end", empty_lo, 0);
                chk_idle("zero after");
            end else begin
                for (int k = 0; k < tbl[v].n; k++) begin
                    chk("vec out_valid_lo", out_valid_lo, 1);
                    chk("vec out_valid_hi", out_valid_hi, 1);
                    chk("vec in_ready_lo", in_ready_lo, 0);
                    chk("vec y_lo", y_lo, tbl[v].lo[3*k +: 3]);
                    chk("vec y_hi", y_hi, tbl[v].hi[3*k +: 3]);
                    chk("vec rem_lo", rem_lo, 32'(tbl[v].n - k));
                    chk("vec rem_hi", rem_hi, 32'(tbl[v].n - k));
                    chk("vec last_lo", last_lo, (k == tbl[v].n - 1) ? 1 : 0);
                    chk("vec last_hi", last_hi, (k == tbl[v].n - 1) ? 1 : 0);
                    chk("vec empty", empty_lo, 0);
                    @(negedge Clk);
                end
                chk_idle("vec end");
            end
        end

        // Back-pressure: 0x81 held for three cycles with Out_Ready low.
        Out_Ready = 1'b0;
        offer(8'h81);
        for (int k = 0; k < 3; k++) begin
            chk("stall y_lo", y_lo, 0);
            chk("stall y_hi", y_hi, 7);
            chk("stall rem_lo", rem_lo, 2);
            chk("stall last_lo", last_lo, 0);
            chk("stall out_valid", out_valid_lo, 1);
            if (k == 2) Out_Ready = 1'b1;
            @(negedge Clk);
        end
        chk("stall2 y_lo", y_lo, 7);
        chk("stall2 y_hi", y_hi, 0);
        chk("stall2 last_lo", last_lo, 1);
        chk("stall2 rem_lo", rem_lo, 1);
        @(negedge Clk);
        chk_idle("stall end");

        // D and In_Valid ignored while emitting.
        offer(8'hA6);
        In_Valid = 1'b1;
        D        = 8'h01;
        for (int k = 0; k < 4; k++) begin
            chk("ign y_lo", y_lo, tbl[0].lo[3*k +: 3]);
            chk("ign y_hi", y_hi, tbl[0].hi[3*k +: 3]);
            chk("ign rem", rem_lo, 32'(4 - k));
            if (k == 3) In_Valid = 1'b0;
            @(negedge Clk);
        end
        chk_idle("ign end");
        @(negedge Clk);
        chk("ign no accept", out_valid_lo, 0);

        // Reset mid-emission after three transfers of 0xFF.
        offer(8'hFF);
        for (int k = 0; k < 3; k++) @(negedge Clk);
        chk("mid y_lo", y_lo, 3);
        chk("mid y_hi", y_hi, 4);
        chk("mid rem", rem_lo, 5);
        Reset = 1'b1;
        #1;
        chk("async out_valid_lo", out_valid_lo, 0);
        chk("async out_valid_hi", out_valid_hi, 0);
        chk("async y_lo", y_lo, 0);
        chk("async y_hi", y_hi, 0);
        chk("async rem", rem_lo, 0);
        chk("async last", last_lo, 0);
        chk("async in_ready", in_ready_lo, 0);
        chk("async empty", empty_lo, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk_idle("after mid rst");
        offer(8'h10);
        chk("new y_lo", y_lo, 4);
        chk("new y_hi", y_hi, 4);
        chk("new last", last_lo, 1);
        chk("new rem", rem_lo, 1);
        chk("new out_valid", out_valid_hi, 1);
        @(negedge Clk);
        chk_idle("new end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
